mult_div: RTL and testbench

Sequential signed multiply/divide unit for the multicycle MIPS datapath, sitting directly downstream of the control unit. The control unit raises a one-cycle start request for `mult` or `div` with operands from registers A and B, then holds in a wait state until this block signals completion. Results land in the architectural HI/LO registers, which the datapath reads for `mfhi`/`mflo` through the MemToReg mux.

---
 rtl/mult_div.sv | 181 ++++++++++++++++++
 tb/tb_mult_div.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// Sequential signed multiply/divide unit for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring divide, one iteration per cycle, results into HI/LO.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        op_div_q, op_div_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] absA, absB;
  logic [32:0] upperExt, mcandExt, boothSum;
  logic [32:0] divShift, divDiff;
  logic [31:0] quoSigned, remSigned;

  assign absA = a[31] ? (~a + 32'd1) : a;
  assign absB = b[31] ? (~b + 32'd1) : b;

  // Booth add/subtract is done one bit wider so a -2^31 multiplicand cannot overflow the upper half.
  assign upperExt = {acc_q[64], acc_q[64:33]};
  assign mcandExt = {opb_q[31], opb_q};
  always_comb begin
    case (acc_q[1:0])
      2'b01:   boothSum = upperExt + mcandExt;
      2'b10:   boothSum = upperExt - mcandExt;
      default: boothSum = upperExt;
    endcase
  end

  // The shifted partial remainder stays below 2^32, so bit 32 of the difference is the borrow.
  assign divShift  = {rem_q, quo_q[31]};
  assign divDiff   = divShift - {1'b0, opb_q};
  assign quoSigned = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign remSigned = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    op_div_d   = op_div_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          acc_d    = {32'd0, b, 1'b0};
          opb_d    = a;
          op_div_d = 1'b0;
          dz_d     = 1'b0;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = MULT;
        end else if (start_div) begin
          op_div_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = 5'd0;
          if (b != 32'd0) begin
            quo_d   = absA;
            rem_d   = 32'd0;
            opb_d   = absB;
            qneg_d  = a[31] ^ b[31];
            rneg_d  = a[31];
            dz_d    = 1'b0;
            state_d = DIV;
          end else begin
            dz_d    = 1'b1;
            state_d = FINISH;
          end
        end
      end
      MULT: begin
        acc_d = {boothSum, acc_q[32:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FINISH;
      end
      DIV: begin
        if (!divDiff[32]) begin
          rem_d = divDiff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = divShift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FINISH;
      end
      FINISH: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (!dz_q) begin
          if (op_div_q) begin
            lo_d = quoSigned;
            hi_d = remSigned;
          end else begin
            hi_d = acc_q[64:33];
            lo_d = acc_q[32:1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 65'd0;
      opb_q      <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      op_div_q   <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      op_div_q   <= op_div_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Testbench for mult_div: a latency/arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        startMult;
  logic        startDiv;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  int          remaining = 0;
  bit          expBusy = 1'b0;
  bit          expDone = 1'b0;
  bit          expDz   = 1'b0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;
  logic [31:0] pendHi = 32'd0;
  logic [31:0] pendLo = 32'd0;
  bit          pendDz = 1'b0;

  mult_div dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (startMult),
    .start_div  (startDiv),
    .a          (opA),
    .b          (opB),
    .busy       (busy),
    .done       (done),
    .div_zero   (divZero),
    .hi         (hi),
    .lo         (lo)
  );

  // free-running clock, 10 time units per period
  always #5 clock = ~clock;

  // one comparison: counts it, and reports any difference with both values
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // signed arithmetic results straight from 64-bit integer math
  function automatic void modelCompute(input bit isMult, input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (isMult) begin
      p  = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // reference model: an accepted request completes a fixed number of cycles later
  always @(posedge clock) begin
    expDone = 1'b0;
    expDz   = 1'b0;
    if (reset) begin
      remaining = 0;
      expBusy   = 1'b0;
      expHi     = 32'd0;
      expLo     = 32'd0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        expBusy = 1'b0;
        expDone = 1'b1;
        expDz   = pendDz;
        if (!pendDz) begin
          expHi = pendHi;
          expLo = pendLo;
        end
      end
    end else if (startMult) begin
      modelCompute(1'b1, opA, opB, pendHi, pendLo);
      pendDz    = 1'b0;
      remaining = 33;
      expBusy   = 1'b1;
    end else if (startDiv) begin
      if (opB == 32'd0) begin
        pendDz    = 1'b1;
        remaining = 1;
      end else begin
        modelCompute(1'b0, opA, opB, pendHi, pendLo);
        pendDz    = 1'b0;
        remaining = 33;
      end
      expBusy = 1'b1;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("div_zero", {31'd0, divZero}, {31'd0, expDz});
      checkOutput("hi", hi, expHi);
      checkOutput("lo", lo, expLo);
    end
  end

  // drive a one-cycle start request from the current negedge, then scramble operands
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y);
    startMult = m;
    startDiv  = d;
    opA       = x;
    opB       = y;
    @(negedge clock);
    startMult = 1'b0;
    startDiv  = 1'b0;
    opA       = $urandom;
    opB       = $urandom;
  endtask

  // bounded wait for done; returns the number of negedges it took
  task automatic waitDone(input int bound, output int k);
    k = 0;
    forever begin
      @(negedge clock);
      k++;
      if (done === 1'b1) return;
      if (k >= bound) begin
        checkOutput("doneTimeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic runOp(input string name, input bit m, input bit d, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eHi, input logic [31:0] eLo);
    int k;
    applyStimulus(m, d, x, y);
    waitDone(40, k);
    checkOutput({name, "_latency"}, 32'(k), 32'd33);
    checkOutput({name, "_hi"}, hi, eHi);
    checkOutput({name, "_lo"}, lo, eLo);
    checkOutput({name, "_busyLow"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    int doneCount;
    int kind;
    logic [31:0] x, y;
    bit m, d;

    reset = 1'b1; startMult = 1'b0; startDiv = 1'b0; opA = 32'd0; opB = 32'd0;
    @(negedge clock);
    checkEn = 1'b1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    runOp("mult7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("multMinSq", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    runOp("divM7by2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divOvf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("divSetup", 1'b0, 1'b1, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022);

    // divide by zero leaves HI/LO alone and finishes after one cycle
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    checkOutput("dz_busyE0", {31'd0, busy}, 32'd1);
    waitDone(5, k);
    checkOutput("dz_latency", 32'(k), 32'd1);
    checkOutput("dz_flag", {31'd0, divZero}, 32'd1);
    checkOutput("dz_busyLow", {31'd0, busy}, 32'd0);
    checkOutput("dz_hi", hi, 32'h11);
    checkOutput("dz_lo", lo, 32'h22);
    @(negedge clock);
    checkOutput("dz_doneDrop", {31'd0, done}, 32'd0);
    checkOutput("dz_flagDrop", {31'd0, divZero}, 32'd0);

    runOp("bothStarts", 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12);

    // a divide request during a running multiply must be dropped
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (9) @(negedge clock);
    startDiv = 1'b1; opA = 32'd100; opB = 32'd7;
    @(negedge clock);
    startDiv = 1'b0;
    waitDone(40, k);
    checkOutput("ignDiv_latency", 32'(k), 32'd23);
    checkOutput("ignDiv_lo", lo, 32'd30);
    checkOutput("ignDiv_hi", hi, 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("ignDiv_extraDone", 32'(doneCount), 32'd0);

    // reset in the middle of a divide discards it
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midRst_hi", hi, 32'd0);
    checkOutput("midRst_lo", lo, 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("midRst_noDone", 32'(doneCount), 32'd0);
    runOp("afterRst", 1'b1, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

    // randomized back-to-back requests, each started in the previous done cycle
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFFFFFF;
      if (kind == 3) begin
        x = $urandom_range(0, 2000);
        y = $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
        if ($urandom_range(0, 1) == 1) y = ~y + 32'd1;
      end
      if ($urandom_range(0, 9) == 0) y = 32'd0;
      m = (kind == 0) || (kind == 2);
      d = (kind != 0);
      applyStimulus(m, d, x, y);
      waitDone(40, k);
      checkOutput("rnd_latency", 32'(k), (m || y != 32'd0) ? 32'd33 : 32'd1);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
